gemm_seq_engine: RTL and testbench

Parametrised, sequential GEMM engine computing R = alpha·(A×B) + beta·C for an M×K by K×N integer matrix product. Operands are loaded element-by-element over a ready/valid write port into internal storage. On start, one multiply-accumulate is performed per cycle and results are streamed out in row-major order over a ready/valid port. It serves as the compute core behind the matrix power-analysis testbenches and replaces the single-cycle combinational formulation with a cycle-accurate, back-pressurable datapath.

---
 rtl/gemm_pkg.sv | 45 ++++
 rtl/gemm_mac_unit.sv | 54 +++++
 rtl/gemm_seq_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_gemm_seq_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// -----------------------------------------------------------------------------
// gemm_pkg
// Shared definitions for the sequential GEMM engine:
//   - sequencer state encoding (IDLE, MAC, SCALE, EMIT, DONE)
//   - operand-select codes for the load port
//   - width helpers used to size index and address fields
// No ports; imported by gemm_seq_engine and its sub-modules.
// -----------------------------------------------------------------------------
package gemm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_MAC   = 3'd1;
  localparam state_t ST_SCALE = 3'd2;
  localparam state_t ST_EMIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // ceil(log2(value)), never below 1 so a degenerate dimension still gets a
  // one-bit field instead of a zero-width vector.
  function automatic int clog2w(input int value);
    int w;
    int pow;
    w   = 32'sd1;
    pow = 32'sd2;
    while (pow < value) begin
      pow = pow * 32'sd2;
      w   = w + 32'sd1;
    end
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/gemm_mac_unit.sv
// -----------------------------------------------------------------------------
// gemm_mac_unit
// Accumulator plus one-shot scale stage for one result element.
//   iclk, irst   clock and synchronous active-high reset
//   i_clr        zero the accumulator (has priority over i_en)
//   i_en         acc += i_a * i_b
//   i_scale      o_res <= i_alpha * acc + i_beta * i_c
//   o_res        registered result, held until the next i_scale
// All arithmetic wraps modulo 2^DATA_WIDTH.
// -----------------------------------------------------------------------------
module gemm_mac_unit
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_scale,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_alpha,
  input  logic [DATA_WIDTH-1:0] i_beta,
  input  logic [DATA_WIDTH-1:0] i_c,
  output logic [DATA_WIDTH-1:0] o_res
);

  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_res;

  // Running dot-product accumulator; products and sums keep only the low bits
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + (i_a * i_b);
    end
  end

  // Scale stage; the result register doubles as the output data holding register
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_res <= '0;
    end else if (i_scale) begin
      r_res <= (i_alpha * r_acc) + (i_beta * i_c);
    end
  end

  assign o_res = r_res;

endmodule

// File: rtl/gemm_seq_engine.sv
// -----------------------------------------------------------------------------
// gemm_seq_engine
// Sequential R = alpha*(A x B) + beta*C, one multiply-accumulate per cycle.
//   iclk, irst              clock, synchronous active-high reset
//   alpha, beta             scale factors, latched when start is accepted
//   ld_valid/ld_ready       operand write handshake (ready only in IDLE)
//   ld_sel, ld_addr, ld_data  target matrix (A/B/C), flat row-major index, value
//   start                   begin a run (IDLE only)
//   busy, done              status; done pulses once after the last result
//   out_valid/out_ready     result handshake
//   out_data, out_row, out_col  result element and its position
// Results leave in row-major order; each costs K MAC + 1 SCALE + 1 EMIT cycle.
// -----------------------------------------------------------------------------
module gemm_seq_engine
  import gemm_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int M          = 4,
  parameter  int N          = 4,
  parameter  int K          = 4,
  parameter  int IDX_WIDTH  = clog2w(max3(M * K, K * N, M * N)),
  localparam int ROW_W      = clog2w(M),
  localparam int COL_W      = clog2w(N)
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [DATA_WIDTH-1:0] alpha,
  input  logic [DATA_WIDTH-1:0] beta,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [1:0]            ld_sel,
  input  logic [IDX_WIDTH-1:0]  ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic [COL_W-1:0]      out_col
);

  localparam int KW     = clog2w(K);
  localparam int A_SIZE = M * K;
  localparam int B_SIZE = K * N;
  localparam int C_SIZE = M * N;

  localparam logic [KW-1:0]    K_LAST   = KW'(K - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);

  logic [DATA_WIDTH-1:0] r_a [A_SIZE];
  logic [DATA_WIDTH-1:0] r_b [B_SIZE];
  logic [DATA_WIDTH-1:0] r_c [C_SIZE];

  state_t                r_state;
  state_t                w_state_nx;
  logic [ROW_W-1:0]      r_i;
  logic [COL_W-1:0]      r_j;
  logic [KW-1:0]         r_k;
  logic [DATA_WIDTH-1:0] r_alpha;
  logic [DATA_WIDTH-1:0] r_beta;
  logic                  r_ld_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_out_valid;

  logic                  w_ld_acc;
  logic                  w_start_acc;
  logic                  w_hs;
  logic                  w_last_k;
  logic                  w_last_el;
  logic                  w_acc_clr;
  logic [IDX_WIDTH-1:0]  w_a_idx;
  logic [IDX_WIDTH-1:0]  w_b_idx;
  logic [IDX_WIDTH-1:0]  w_c_idx;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH-1:0] w_op_c;
  logic [DATA_WIDTH-1:0] w_res;

  assign w_ld_acc    = ld_valid & r_ld_ready;
  assign w_start_acc = start & (r_state == ST_IDLE);
  assign w_hs        = out_ready & (r_state == ST_EMIT);
  assign w_last_k    = (r_k == K_LAST);
  assign w_last_el   = (r_i == ROW_LAST) && (r_j == COL_LAST);
  // Clear on a fresh run and when moving on to the next element
  assign w_acc_clr   = w_start_acc | (w_hs & ~w_last_el);

  // Flat row-major operand addresses; all fit in IDX_WIDTH by construction
  assign w_a_idx = (IDX_WIDTH'(r_i) * IDX_WIDTH'(K)) + IDX_WIDTH'(r_k);
  assign w_b_idx = (IDX_WIDTH'(r_k) * IDX_WIDTH'(N)) + IDX_WIDTH'(r_j);
  assign w_c_idx = (IDX_WIDTH'(r_i) * IDX_WIDTH'(N)) + IDX_WIDTH'(r_j);

  assign w_op_a = r_a[w_a_idx];
  assign w_op_b = r_b[w_b_idx];
  assign w_op_c = r_c[w_c_idx];

  // Operand storage: writes only while idle; bad addresses and the reserved select are dropped
  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int n = 0; n < A_SIZE; n++) r_a[n] <= '0;
      for (int n = 0; n < B_SIZE; n++) r_b[n] <= '0;
      for (int n = 0; n < C_SIZE; n++) r_c[n] <= '0;
    end else if (w_ld_acc) begin
      case (ld_sel)
        SEL_A:   if (32'(ld_addr) < 32'(A_SIZE)) r_a[ld_addr] <= ld_data;
        SEL_B:   if (32'(ld_addr) < 32'(B_SIZE)) r_b[ld_addr] <= ld_data;
        SEL_C:   if (32'(ld_addr) < 32'(C_SIZE)) r_c[ld_addr] <= ld_data;
        default: ;
      endcase
    end
  end

  // Scale factors captured at start so the caller may change them mid-run
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_alpha <= '0;
      r_beta  <= '0;
    end else if (w_start_acc) begin
      r_alpha <= alpha;
      r_beta  <= beta;
    end
  end

  // Next-state decode for the sequencer
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nx = ST_MAC;
        else       w_state_nx = ST_IDLE;
      end
      ST_MAC: begin
        if (w_last_k) w_state_nx = ST_SCALE;
        else          w_state_nx = ST_MAC;
      end
      ST_SCALE: w_state_nx = ST_EMIT;
      ST_EMIT: begin
        if (!out_ready)     w_state_nx = ST_EMIT;
        else if (w_last_el) w_state_nx = ST_DONE;
        else                w_state_nx = ST_MAC;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State register; status flags are decoded from the next state so they leave on flops
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state     <= ST_IDLE;
      r_ld_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ld_ready  <= (w_state_nx == ST_IDLE);
      r_busy      <= (w_state_nx != ST_IDLE);
      r_done      <= (w_state_nx == ST_DONE);
      r_out_valid <= (w_state_nx == ST_EMIT);
    end
  end

  // Element and inner-loop counters; frozen while EMIT is stalled
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
          end
        end
        ST_MAC: begin
          if (w_last_k) r_k <= '0;
          else          r_k <= r_k + KW'(1);
        end
        ST_EMIT: begin
          if (out_ready && !w_last_el) begin
            r_k <= '0;
            if (r_j == COL_LAST) begin
              r_j <= '0;
              r_i <= r_i + ROW_W'(1);
            end else begin
              r_j <= r_j + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  gemm_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac (
    .iclk    (iclk),
    .irst    (irst),
    .i_clr   (w_acc_clr),
    .i_en    (r_state == ST_MAC),
    .i_scale (r_state == ST_SCALE),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .i_alpha (r_alpha),
    .i_beta  (r_beta),
    .i_c     (w_op_c),
    .o_res   (w_res)
  );

  assign ld_ready  = r_ld_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_data  = w_res;
  assign out_row   = r_i;
  assign out_col   = r_j;

endmodule

// File: tb/tb_gemm_seq_engine.sv
// -----------------------------------------------------------------------------
// tb_gemm_seq_engine
// Directed bench for gemm_seq_engine (M=N=K=4, 32-bit data). A table of
// uniform-fill cases with hand-computed results is run first, followed by
// hand-written sequences: identity, wrap-around, back-pressure, protocol
// corner cases and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_gemm_seq_engine;
  import gemm_pkg::*;

  localparam int DW    = 32;
  localparam int MM    = 4;
  localparam int NN    = 4;
  localparam int KK    = 4;
  localparam int NEL   = MM * NN;
  localparam int LIMIT = 400;

  logic          iclk;
  logic          irst;
  logic [DW-1:0] alpha;
  logic [DW-1:0] beta;
  logic          ld_valid;
  logic          ld_ready;
  logic [1:0]    ld_sel;
  logic [3:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_row;
  logic [1:0]    out_col;

  int n_chk;
  int n_fail;
  logic [DW-1:0] exp_r [NEL];

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] al;
    logic [DW-1:0] be;
    logic [DW-1:0] r;
    bit            rsv;
  } vec_t;

  vec_t vecs [6];

  gemm_seq_engine #(
    .DATA_WIDTH (DW),
    .M          (MM),
    .N          (NN),
    .K          (KK)
  ) dut (
    .iclk      (iclk),
    .irst      (irst),
    .alpha     (alpha),
    .beta      (beta),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic ld_one(input logic [1:0] sel, input int addr, input logic [DW-1:0] d);
    @(negedge iclk);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = 4'(addr);
    ld_data  = d;
  endtask

  task automatic ld_end();
    @(negedge iclk);
    ld_valid = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [DW-1:0] cv);
    for (int n = 0; n < 16; n++) ld_one(SEL_A, n, av);
    for (int n = 0; n < 16; n++) ld_one(SEL_B, n, bv);
    for (int n = 0; n < 16; n++) ld_one(SEL_C, n, cv);
    ld_end();
  endtask

  // One full run: start (optionally with a same-cycle load), drain all results
  // against exp_r, optionally stall one element or poke the DUT while busy.
  // Cycle n below is the interval right after edge t+n, t = start edge.
  task automatic run_job(input string nm, input logic [DW-1:0] al, input logic [DW-1:0] be,
                         input int stall_el, input int stall_len, input bit disturb,
                         input bit sim_ld, input logic [DW-1:0] sim_val);
    int el;
    int cyc;
    int stall_left;
    int first_v;
    int done_cyc;
    el = 0; stall_left = stall_len; first_v = -1; done_cyc = -1;
    out_ready = 1'b1;
    @(negedge iclk);
    alpha = al;
    beta  = be;
    start = 1'b1;
    if (sim_ld) begin
      ld_valid = 1'b1; ld_sel = SEL_A; ld_addr = 4'd15; ld_data = sim_val;
    end
    @(negedge iclk);
    start = 1'b0; ld_valid = 1'b0;
    alpha = 32'h0; beta = 32'h0;
    cyc = 0;
    chk({nm, "/busy_after_start"}, 64'(busy), 64'd1);
    while (done_cyc < 0 && cyc < LIMIT) begin
      if (disturb && cyc == 1) start = 1'b1;
      if (disturb && cyc == 2) begin
        start = 1'b0;
        chk({nm, "/ld_ready_busy"}, 64'(ld_ready), 64'd0);
        ld_valid = 1'b1; ld_sel = SEL_A; ld_addr = 4'd1; ld_data = 32'd50;
      end
      if (disturb && cyc == 3) ld_valid = 1'b0;
      if (out_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          chk({nm, "/first_valid_cyc"}, 64'(first_v), 64'(KK + 1));
        end
        if (el >= NEL) begin
          n_chk++; n_fail++;
          $display("FAIL %s/extra_element: got element %0d, required at most %0d", nm, el, NEL);
          out_ready = 1'b1;
        end else begin
          chk($sformatf("%s/data[%0d]", nm, el), 64'(out_data), 64'(exp_r[el]));
          chk($sformatf("%s/row[%0d]", nm, el), 64'(out_row), 64'(el / NN));
          chk($sformatf("%s/col[%0d]", nm, el), 64'(out_col), 64'(el % NN));
          if (el == stall_el && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
            el++;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) done_cyc = cyc;
      else begin
        @(negedge iclk);
        cyc++;
      end
    end
    chk({nm, "/done_cyc"}, 64'(done_cyc), 64'(NEL * (KK + 2) + stall_len));
    chk({nm, "/count"}, 64'(el), 64'(NEL));
    chk({nm, "/ld_ready_in_done"}, 64'(ld_ready), 64'd0);
    @(negedge iclk);
    chk({nm, "/ld_ready_back"}, 64'(ld_ready), 64'd1);
    chk({nm, "/busy_back"}, 64'(busy), 64'd0);
    chk({nm, "/done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    n_chk = 0; n_fail = 0;
    irst = 1'b1; alpha = '0; beta = '0; ld_valid = 1'b0; ld_sel = 2'd0;
    ld_addr = 4'd0; ld_data = '0; start = 1'b0; out_ready = 1'b1;

    //              a             b             c             alpha         beta   result
    vecs[0] = '{32'd2,       32'd2,       32'd5,        32'd3,        32'd7, 32'd83,        1'b1};
    vecs[1] = '{32'd1,       32'd1,       32'd0,        32'd1,        32'd0, 32'd4,         1'b0};
    vecs[2] = '{32'd0,       32'd9,       32'd10,       32'd5,        32'd3, 32'd30,        1'b0};
    vecs[3] = '{32'h10000,   32'h10000,   32'd1,        32'd1,        32'd1, 32'd1,         1'b0};
    vecs[4] = '{32'd3,       32'd5,       32'd2,        32'hFFFFFFFF, 32'd0, 32'hFFFFFFC4,  1'b0};
    vecs[5] = '{32'h80000000, 32'd1,      32'h80000000, 32'd1,        32'd1, 32'h80000000,  1'b0};

    // reset state
    repeat (2) @(negedge iclk);
    chk("rst/ld_ready", 64'(ld_ready), 64'd1);
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/out_valid", 64'(out_valid), 64'd0);
    chk("rst/out_data", 64'(out_data), 64'd0);
    chk("rst/out_row", 64'(out_row), 64'd0);
    chk("rst/out_col", 64'(out_col), 64'd0);
    irst = 1'b0;

    // uniform-fill table; rsv also writes ld_sel=3, which must be ignored
    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].a, vecs[v].b, vecs[v].c);
      if (vecs[v].rsv) begin
        ld_one(2'd3, 0, 32'd100);
        ld_end();
      end
      for (int e = 0; e < NEL; e++) exp_r[e] = vecs[v].r;
      run_job($sformatf("vec%0d", v), vecs[v].al, vecs[v].be, -1, 0, 1'b0, 1'b0, 32'd0);
    end

    // identity: A = I, B[idx] = idx+1, C = 0 -> R = B
    for (int e = 0; e < 16; e++) ld_one(SEL_A, e, ((e / 4) == (e % 4)) ? 32'd1 : 32'd0);
    for (int e = 0; e < 16; e++) ld_one(SEL_B, e, 32'(e + 1));
    for (int e = 0; e < 16; e++) ld_one(SEL_C, e, 32'd0);
    ld_end();
    for (int e = 0; e < NEL; e++) exp_r[e] = 32'(e + 1);
    run_job("ident", 32'd1, 32'd0, -1, 0, 1'b0, 1'b0, 32'd0);

    // wrap-around: (2^32-1)^2 mod 2^32 = 1
    fill(32'd0, 32'd0, 32'd0);
    ld_one(SEL_A, 0, 32'hFFFFFFFF);
    ld_one(SEL_B, 0, 32'hFFFFFFFF);
    ld_end();
    for (int e = 0; e < NEL; e++) exp_r[e] = 32'd0;
    exp_r[0] = 32'd1;
    run_job("wrap", 32'd1, 32'd0, -1, 0, 1'b0, 1'b0, 32'd0);

    // back-pressure: 5 stalled cycles on R[1][2] (element 6)
    fill(32'd2, 32'd2, 32'd5);
    for (int e = 0; e < NEL; e++) exp_r[e] = 32'd83;
    run_job("bp", 32'd3, 32'd7, 6, 5, 1'b0, 1'b0, 32'd0);

    // start during MAC ignored, load while busy not acknowledged nor written
    run_job("proto", 32'd3, 32'd7, -1, 0, 1'b1, 1'b0, 32'd0);

    // load of A[3][3] in the same cycle as start is used by the run
    fill(32'd1, 32'd1, 32'd0);
    for (int e = 0; e < NEL; e++) exp_r[e] = (e >= 12) ? 32'd13 : 32'd4;
    run_job("simul", 32'd1, 32'd0, -1, 0, 1'b0, 1'b1, 32'd10);

    // reset during MAC of element (2,1), then rerun on cleared storage
    fill(32'd1, 32'd1, 32'd1);
    @(negedge iclk);
    alpha = 32'd1; beta = 32'd1; start = 1'b1;
    @(negedge iclk);
    start = 1'b0;
    n = 0;
    while (!(busy && !out_valid && out_row == 2'd2 && out_col == 2'd1) && n < LIMIT) begin
      @(negedge iclk);
      n++;
    end
    chk("rstmid/reached", 64'(n < LIMIT), 64'd1);
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    chk("rstmid/busy", 64'(busy), 64'd0);
    chk("rstmid/out_valid", 64'(out_valid), 64'd0);
    chk("rstmid/out_data", 64'(out_data), 64'd0);
    chk("rstmid/ld_ready", 64'(ld_ready), 64'd1);
    for (int e = 0; e < NEL; e++) exp_r[e] = 32'd0;
    run_job("rstmid_rerun", 32'd1, 32'd1, -1, 0, 1'b0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
